// File: rtl/aes_iter_core_if.sv
// Block-level bus for aes_iter_core: plaintext/key in, ciphertext/last round key out.
//
// Handshake: a transfer happens on a rising clk edge where the sender's valid
// and the receiver's ready are both high. A sender keeps its valid high and its
// payload stable until that edge; ready may rise or fall freely and never
// waits on valid. in_* carries plaintext/key into the core, out_* carries the
// finished ciphertext and the last round key out of it.
interface aes_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] s_out;
  logic [127:0] k_out;
  logic         busy;

  modport master (
    output in_valid, state_in, key_in, out_ready,
    input  in_ready, out_valid, s_out, k_out, busy
  );

  modport slave (
    input  in_valid, state_in, key_in, out_ready,
    output in_ready, out_valid, s_out, k_out, busy
  );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one round per clock, round keys expanded
// on the fly next to the datapath. NR rounds, final round skips MixColumns.
// Byte 0 of every 128-bit word sits in bits [127:120] (FIPS-197 column order).
module aes_iter_core #(
  parameter int NR         = 10,
  parameter int KEY_ON_FLY = 1
) (
  input  logic          clk,
  input  logic          rst,
  aes_iter_core_if.slave io,
  output logic [1:0]    state_dbg
);

  if (NR < 1 || NR > 10) begin : g_bad_nr
    $error("aes_iter_core: NR must be in 1..10");
  end
  if (KEY_ON_FLY != 1) begin : g_bad_kof
    $error("aes_iter_core: only on-the-fly key expansion is supported");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Byte 0 at index 0, which is also the most significant byte.
  typedef logic [0:15][7:0] blk_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // One AES-128 key expansion step: four S-boxes on RotWord of the last word.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sub_byte(w3[23:16]) ^ rc, sub_byte(w3[15:8]),
          sub_byte(w3[7:0]), sub_byte(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes, ShiftRows, MixColumns (unless last), AddRoundKey.
  function automatic logic [127:0] enc_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    blk_t b, sb, sr, mc;
    b = s;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sub_byte(b[i]);
    end
    sr = {sb[0],  sb[5],  sb[10], sb[15],
          sb[4],  sb[9],  sb[14], sb[3],
          sb[8],  sb[13], sb[2],  sb[7],
          sb[12], sb[1],  sb[6],  sb[11]};
    mc = sr;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
          mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
      end
    end
    return mc ^ rk;
  endfunction

  state_t       st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] dat_q, dat_d;
  logic [127:0] key_q, key_d;
  logic [127:0] s_out_q, s_out_d;
  logic [127:0] k_out_q, k_out_d;

  logic         last_round;
  logic [127:0] round_key;
  logic [127:0] round_out;

  // Next round key and round result from the current counter/key/state.
  always_comb begin
    last_round = (cnt_q == NR_L);
    round_key  = key_step(key_q, rcon(cnt_q));
    round_out  = enc_round(dat_q, round_key, last_round);
  end

  // Next-state logic: accept in IDLE, one round per cycle in RUN, hold in DONE.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    key_d   = key_q;
    s_out_d = s_out_q;
    k_out_d = k_out_q;
    case (st_q)
      S_IDLE: begin
        if (io.in_valid) begin
          dat_d = io.state_in ^ io.key_in;
          key_d = io.key_in;
          cnt_d = 4'd1;
          st_d  = S_RUN;
        end
      end
      S_RUN: begin
        dat_d = round_out;
        key_d = round_key;
        if (last_round) begin
          s_out_d = round_out;
          k_out_d = round_key;
          st_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (io.out_ready) begin
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // State, datapath and result registers; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cnt_q   <= 4'd0;
      dat_q   <= '0;
      key_q   <= '0;
      s_out_q <= '0;
      k_out_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      key_q   <= key_d;
      s_out_q <= s_out_d;
      k_out_q <= k_out_d;
    end
  end

  assign io.in_ready  = (st_q == S_IDLE) && !rst;
  assign io.out_valid = (st_q == S_DONE);
  assign io.busy      = (st_q == S_RUN);
  assign io.s_out     = s_out_q;
  assign io.k_out     = k_out_q;
  assign state_dbg    = st_q;

endmodule
